cfg_scan_ctrl: RTL and testbench

CFG_SCAN_CTRL -- requirements
Module: cfg_scan_ctrl

---
 rtl/cfg_scan_ctrl_if.sv | 14 +
 rtl/cfg_scan_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_cfg_scan_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_scan_ctrl_if.sv
// Byte-stream handshake between the SPI front end (master) and cfg_scan_ctrl (slave).
interface cfg_scan_ctrl_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (output rx_valid, output rx_data, input rx_ready,
                    input tx_valid, input tx_data, output tx_ready);
    modport slave  (input rx_valid, input rx_data, output rx_ready,
                    output tx_valid, output tx_data, input tx_ready);
endinterface

// File: rtl/cfg_scan_ctrl.sv
// SPI-configured channel scanner; register readback is built only with CFG_SCAN_READBACK_EN.
// state   | meaning
// F_CMD   | waiting for a command byte
// F_DATA  | write command taken, waiting for its data byte (idle timeout armed)
// S_IDLE  | no scan, sel=0
// S_DWELL | channel ch selected for DWELL+1 cycles
// S_ADV   | one break-before-make cycle, then step to the next enabled channel
module cfg_scan_ctrl #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic           clk,
    input  logic           rst,
    cfg_scan_ctrl_if.slave spi,
    output logic [7:0]     sel,
    output logic           busy
);
    localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    typedef enum logic {F_CMD, F_DATA} fstate_t;
    typedef enum logic [1:0] {S_IDLE, S_DWELL, S_ADV} sstate_t;

    fstate_t r_fstate, w_fstate_nxt;
    sstate_t r_sstate, w_sstate_nxt;

    logic          r_scan_en, r_oneshot, r_err;
    logic [7:0]    r_mask, r_dwell, r_dw_cnt;
    logic [2:0]    r_ch, r_addr;
    logic [TW-1:0] r_to_cnt;

    logic       w_rx_acc, w_wr, w_timeout;
    logic       w_stop, w_wrap, w_oneshot_clr;
    logic [7:0] w_above;
    logic [2:0] w_next_ch;

    function automatic logic [2:0] f_lowest(input logic [7:0] m);
        f_lowest = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) f_lowest = 3'(i);
        end
    endfunction

    assign w_rx_acc  = spi.rx_valid && spi.rx_ready;
    assign w_wr      = (r_fstate == F_DATA) && w_rx_acc;
    assign w_timeout = (r_fstate == F_DATA) && !w_rx_acc && (r_to_cnt <= TW'(1));

    always_ff @(posedge clk) begin
        if (rst) r_fstate <= F_CMD;
        else     r_fstate <= w_fstate_nxt;
    end

    always_comb begin
        w_fstate_nxt = r_fstate;
        case (r_fstate)
            F_CMD:   if (w_rx_acc && spi.rx_data[7]) w_fstate_nxt = F_DATA;
            F_DATA:  if (w_rx_acc || w_timeout)      w_fstate_nxt = F_CMD;
            default: w_fstate_nxt = F_CMD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_to_cnt <= '0;
        end else if (r_fstate == F_CMD && w_rx_acc) begin
            r_addr   <= spi.rx_data[2:0];
            r_to_cnt <= TW'(TIMEOUT_CYC);
        end else if (r_fstate == F_DATA && !w_rx_acc) begin
            r_to_cnt <= r_to_cnt - TW'(1);
        end
    end

    // A CTRL write lands after the auto-clear so it wins when both hit one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_en <= 1'b0;
            r_oneshot <= 1'b0;
            r_mask    <= 8'h00;
            r_dwell   <= 8'h00;
        end else begin
            if (w_oneshot_clr) begin
                r_scan_en <= 1'b0;
                r_oneshot <= 1'b0;
            end
            if (w_wr) begin
                case (r_addr)
                    3'd0: begin
                        r_scan_en <= spi.rx_data[0];
                        r_oneshot <= spi.rx_data[1];
                    end
                    3'd1:    r_mask  <= spi.rx_data;
                    3'd2:    r_dwell <= spi.rx_data;
                    default: ;
                endcase
            end
        end
    end

`ifdef CFG_SCAN_READBACK_EN
    logic       r_tx_valid, w_rd;
    logic [7:0] r_tx_data, w_rd_val;

    assign w_rd = (r_fstate == F_CMD) && w_rx_acc && !spi.rx_data[7];

    always_comb begin
        w_rd_val = 8'h00;
        case (spi.rx_data[2:0])
            3'd0:    w_rd_val = {6'b0, r_oneshot, r_scan_en};
            3'd1:    w_rd_val = r_mask;
            3'd2:    w_rd_val = r_dwell;
            3'd3:    w_rd_val = {busy, r_err, 3'b000, r_ch};
            default: w_rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else if (w_rd) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_rd_val;
        end else if (r_tx_valid && spi.tx_ready) begin
            r_tx_valid <= 1'b0;
        end
    end

    // The STATUS byte captured above still carries err=1; it clears on the same edge.
    always_ff @(posedge clk) begin
        if (rst)                                   r_err <= 1'b0;
        else if (w_timeout)                        r_err <= 1'b1;
        else if (w_rd && spi.rx_data[2:0] == 3'd3) r_err <= 1'b0;
    end

    assign spi.rx_ready = !r_tx_valid;
    assign spi.tx_valid = r_tx_valid;
    assign spi.tx_data  = r_tx_data;
`else
    logic w_unused_rb;

    always_ff @(posedge clk) begin
        if (rst)            r_err <= 1'b0;
        else if (w_timeout) r_err <= 1'b1;
    end

    assign w_unused_rb  = spi.tx_ready ^ r_err;
    assign spi.rx_ready = 1'b1;
    assign spi.tx_valid = 1'b0;
    assign spi.tx_data  = 8'h00;
`endif

    assign w_stop        = !r_scan_en || (r_mask == 8'h00);
    assign w_above       = r_mask & (8'hFE << r_ch);
    assign w_wrap        = (w_above == 8'h00);
    assign w_next_ch     = w_wrap ? f_lowest(r_mask) : f_lowest(w_above);
    assign w_oneshot_clr = (r_sstate == S_ADV) && !w_stop && w_wrap && r_oneshot;

    always_ff @(posedge clk) begin
        if (rst) r_sstate <= S_IDLE;
        else     r_sstate <= w_sstate_nxt;
    end

    always_comb begin
        w_sstate_nxt = r_sstate;
        case (r_sstate)
            S_IDLE:  if (!w_stop) w_sstate_nxt = S_DWELL;
            S_DWELL: begin
                if (w_stop)                  w_sstate_nxt = S_IDLE;
                else if (r_dw_cnt == 8'h00)  w_sstate_nxt = S_ADV;
            end
            S_ADV:   begin
                if (w_stop || (w_wrap && r_oneshot)) w_sstate_nxt = S_IDLE;
                else                                 w_sstate_nxt = S_DWELL;
            end
            default: w_sstate_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch     <= 3'd0;
            r_dw_cnt <= 8'h00;
        end else begin
            case (r_sstate)
                S_IDLE: if (!w_stop) begin
                    r_ch     <= f_lowest(r_mask);
                    r_dw_cnt <= r_dwell;
                end
                S_DWELL: if (r_dw_cnt != 8'h00) r_dw_cnt <= r_dw_cnt - 8'd1;
                S_ADV: if (w_sstate_nxt == S_DWELL) begin
                    r_ch     <= w_next_ch;
                    r_dw_cnt <= r_dwell;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sel  = 8'h00;
        busy = 1'b0;
        case (r_sstate)
            S_DWELL: begin
                sel  = 8'd1 << r_ch;
                busy = 1'b1;
            end
            S_ADV:   busy = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cfg_scan_ctrl.sv
// Directed plus randomized bench for cfg_scan_ctrl against an arithmetic scan/register model.
module tb_cfg_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sel;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] m_ctrl;
    logic [7:0] m_mask, m_dwell;
    logic       m_err;
    logic [8:0] e_tmp;

    cfg_scan_ctrl_if spi_if ();

    cfg_scan_ctrl #(.TIMEOUT_CYC(255)) dut (
        .clk  (clk),
        .rst  (rst),
        .spi  (spi_if),
        .sel  (sel),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // {busy, sel} k cycles after the scan leaves idle: each enabled channel
    // in ascending order for dwell+1 cycles, then one blank cycle.
    function automatic logic [8:0] exp_scan(input int k, input logic [7:0] mask,
                                            input logic [7:0] dwell, input logic oneshot);
        int chs[$];
        int per, total, p, idx, r;
        for (int i = 0; i < 8; i++) if (mask[i]) chs.push_back(i);
        if (chs.size() == 0) return 9'h000;
        per   = int'(dwell) + 2;
        total = per * chs.size();
        if (oneshot && k >= total) return 9'h000;
        p   = k % total;
        idx = p / per;
        r   = p % per;
        if (r <= int'(dwell)) return {1'b1, 8'(1 << chs[idx])};
        return {1'b1, 8'h00};
    endfunction

    function automatic logic [7:0] model_rd(input logic [2:0] a);
        case (a)
            3'd0:    return {6'b0, m_ctrl};
            3'd1:    return m_mask;
            3'd2:    return m_dwell;
            3'd3:    return {1'b0, m_err, 6'b0};
            default: return 8'h00;
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] b);
        logic ok;
        spi_if.rx_valid = 1'b1;
        spi_if.rx_data  = b;
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            ok = spi_if.rx_ready;
            tick();
        end
        chk("rx_accept", {7'b0, ok}, 8'h01);
        spi_if.rx_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ctrl = 2'b00; m_mask = 8'h00; m_dwell = 8'h00; m_err = 1'b0;
        chk({tag, "_sel"},   sel, 8'h00);
        chk({tag, "_busy"},  {7'b0, busy}, 8'h00);
        chk({tag, "_txv"},   {7'b0, spi_if.tx_valid}, 8'h00);
        chk({tag, "_txd"},   spi_if.tx_data, 8'h00);
        chk({tag, "_rxrdy"}, {7'b0, spi_if.rx_ready}, 8'h01);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        send_byte({1'b1, 4'($urandom_range(0, 15)), a});
        send_byte(d);
        case (a)
            3'd0:    m_ctrl  = d[1:0];
            3'd1:    m_mask  = d;
            3'd2:    m_dwell = d;
            default: ;
        endcase
    endtask

    task automatic rd_reg(input logic [2:0] a, input string tag);
`ifdef CFG_SCAN_READBACK_EN
        logic [7:0] e;
        e = model_rd(a);
`endif
        send_byte({1'b0, 4'($urandom_range(0, 15)), a});
`ifdef CFG_SCAN_READBACK_EN
        chk({tag, "_txv"},   {7'b0, spi_if.tx_valid}, 8'h01);
        chk({tag, "_data"},  spi_if.tx_data, e);
        chk({tag, "_rxrdy"}, {7'b0, spi_if.rx_ready}, 8'h00);
        if (a == 3'd3) m_err = 1'b0;
        spi_if.tx_ready = 1'b1;
        tick();
        spi_if.tx_ready = 1'b0;
        chk({tag, "_txdone"}, {7'b0, spi_if.tx_valid}, 8'h00);
`else
        chk({tag, "_txv"},  {7'b0, spi_if.tx_valid}, 8'h00);
        chk({tag, "_txd"},  spi_if.tx_data, 8'h00);
`endif
        chk({tag, "_rxrdy_end"}, {7'b0, spi_if.rx_ready}, 8'h01);
    endtask

    // Call right after the CTRL data byte is accepted (scan still idle).
    task automatic run_scan(input int n, input string tag);
        logic [8:0] e;
        int total;
        chk({tag, "_idle0"}, {7'b0, busy}, 8'h00);
        for (int k = 0; k < n; k++) begin
            tick();
            e = exp_scan(k, m_mask, m_dwell, m_ctrl[1]);
            chk($sformatf("%s_sel%0d", tag, k), sel, e[7:0]);
            chk($sformatf("%s_busy%0d", tag, k), {7'b0, busy}, {7'b0, e[8]});
        end
        total = (int'(m_dwell) + 2) * $countones(m_mask);
        if (m_ctrl[1] && m_mask != 8'h00 && n >= total) m_ctrl = 2'b00;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        spi_if.rx_valid = 1'b0;
        spi_if.rx_data  = 8'h00;
        spi_if.tx_ready = 1'b0;
        tick();
        do_reset("reset");

        // Two-channel continuous scan, then MASK cleared mid-dwell.
        wr_reg(3'd2, 8'h02);
        wr_reg(3'd1, 8'h05);
        wr_reg(3'd0, 8'h01);
        run_scan(20, "scan05");
        e_tmp = exp_scan(21, m_mask, m_dwell, m_ctrl[1]);
        wr_reg(3'd1, 8'h00);
        chk("mask0_c1_sel", sel, e_tmp[7:0]);
        tick();
        chk("mask0_sel",  sel, 8'h00);
        chk("mask0_busy", {7'b0, busy}, 8'h00);
        wr_reg(3'd0, 8'h00);

        // Oneshot over a single top channel.
        wr_reg(3'd2, 8'h00);
        wr_reg(3'd1, 8'h80);
        wr_reg(3'd0, 8'h03);
        run_scan(5, "oneshot80");
        rd_reg(3'd0, "ctrl_after_oneshot");

        // CTRL write on the same edge as the oneshot auto-clear.
        wr_reg(3'd1, 8'h01);
        wr_reg(3'd0, 8'h03);
        tick();
        send_byte({1'b1, 4'($urandom_range(0, 15)), 3'd0});
        send_byte(8'h03);
        m_ctrl = 2'b11;
        run_scan(4, "ctrl_prio");
        rd_reg(3'd0, "ctrl_prio_rd");

        for (int r = 0; r < 6; r++) begin
            wr_reg(3'd2, 8'($urandom_range(0, 3)));
            wr_reg(3'd1, 8'($urandom_range(0, 255)));
            wr_reg(3'd0, {6'b0, 1'($urandom_range(0, 1)), 1'b1});
            n = 2 * (int'(m_dwell) + 2) * $countones(m_mask) + 3;
            run_scan(n, $sformatf("rnd%0d", r));
            rd_reg(3'd0, $sformatf("rnd%0d_ctrl", r));
            wr_reg(3'd0, 8'h00);
            tick();
            chk($sformatf("rnd%0d_stop_sel", r), sel, 8'h00);
            chk($sformatf("rnd%0d_stop_busy", r), {7'b0, busy}, 8'h00);
        end

        // Reset in the middle of a write frame, then a clean DWELL write.
        send_byte(8'h81);
        tick();
        do_reset("rst_midframe");
        send_byte(8'h82);
        send_byte(8'h10);
        m_dwell = 8'h10;

        // Data byte after 254 idle cycles still completes the write.
        send_byte(8'h81);
        repeat (254) tick();
        send_byte(8'h24);
        m_mask = 8'h24;
        rd_reg(3'd3, "status_no_err");

        // 255 idle cycles abort the frame.
        send_byte(8'h81);
        repeat (255) tick();
        m_err = 1'b1;
        rd_reg(3'd3, "status_err");
        rd_reg(3'd3, "status_cleared");
        rd_reg(3'd1, "mask_kept");
        rd_reg(3'd2, "dwell_after_rst");
        wr_reg(3'd0, 8'h03);
        run_scan(40, "scan24");

        // Readback of DWELL held off by tx_ready=0.
        send_byte(8'h02);
        for (int i = 0; i < 5; i++) begin
`ifdef CFG_SCAN_READBACK_EN
            chk($sformatf("hold%0d_txv", i),   {7'b0, spi_if.tx_valid}, 8'h01);
            chk($sformatf("hold%0d_txd", i),   spi_if.tx_data, m_dwell);
            chk($sformatf("hold%0d_rxrdy", i), {7'b0, spi_if.rx_ready}, 8'h00);
`else
            chk($sformatf("hold%0d_txv", i),   {7'b0, spi_if.tx_valid}, 8'h00);
            chk($sformatf("hold%0d_txd", i),   spi_if.tx_data, 8'h00);
            chk($sformatf("hold%0d_rxrdy", i), {7'b0, spi_if.rx_ready}, 8'h01);
`endif
            tick();
        end
        spi_if.tx_ready = 1'b1;
        tick();
        spi_if.tx_ready = 1'b0;
        chk("hold_done_txv",   {7'b0, spi_if.tx_valid}, 8'h00);
        chk("hold_done_rxrdy", {7'b0, spi_if.rx_ready}, 8'h01);

        // Reset drops a pending readback and a running scan.
        wr_reg(3'd2, 8'h03);
        wr_reg(3'd1, 8'h01);
        wr_reg(3'd0, 8'h01);
        tick();
        tick();
        chk("pre_rst_sel", sel, 8'h01);
        send_byte(8'h01);
        do_reset("rst_pending");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
